// File: rtl/prefetch_credit_controller.sv
// rtl/prefetch_credit_controller.sv - credit-gated strided tile read request sequencer
//
// Purpose: pops prefetch commands (first-word fall-through FIFO) and expands
// each into single-tile read requests at strided addresses. A request is only
// presented while the L3 tile FIFO is guaranteed room for the returning tile,
// i.e. while outstanding + occupied < L3_DEPTH.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   cmd_valid/cmd_re    - command available / one-cycle pop
//   cmd_copy_count      - tiles to fetch (0 discards the command)
//   cmd_addr/cmd_stride - first tile address / address increment (mod 2^18)
//   req_valid/req_ready - tile read request handshake, req_addr its address
//   tile_arrive         - L3 write strobe (requested tile returned)
//   tile_consume        - L3 read strobe (tile popped downstream)
//   outstanding         - accepted requests whose tile has not yet arrived
//   occupied            - arrived tiles not yet consumed
//   busy                - FSM not in IDLE
//   err                 - sticky underflow error on either counter
module prefetch_credit_controller #(
  parameter int L3_DEPTH = 16,
  parameter int CW       = $clog2(L3_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [4:0]    cmd_copy_count,
  input  logic [17:0]   cmd_addr,
  input  logic [17:0]   cmd_stride,
  output logic          cmd_re,
  output logic          req_valid,
  output logic [17:0]   req_addr,
  input  logic          req_ready,
  input  logic          tile_arrive,
  input  logic          tile_consume,
  output logic [CW-1:0] outstanding,
  output logic [CW-1:0] occupied,
  output logic          busy,
  output logic          err
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(L3_DEPTH);

  state_t        state_q, state_d;
  logic [4:0]    remaining_q, remaining_d;
  logic [17:0]   cur_addr_q, cur_addr_d;
  logic [17:0]   stride_q, stride_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] occupied_q, occupied_d;
  logic          err_q, err_d;

  logic          credit;
  logic          handshake;
  logic          arrive_ok;
  logic          consume_ok;

  // Credit only shrinks through issuance (arrive moves a tile from
  // outstanding to occupied, consume frees one), so a presented request
  // can safely be held until accepted.
  assign credit    = ({1'b0, outstanding_q} + {1'b0, occupied_q}) < DEPTH_W;
  assign req_valid = (state_q == ISSUE) && credit;
  assign handshake = req_valid && req_ready;
  assign cmd_re    = (state_q == IDLE) && cmd_valid;

  // Underflowing strobes are flagged and not applied to the counter.
  assign arrive_ok  = tile_arrive && (outstanding_q != '0);
  assign consume_ok = tile_consume && (occupied_q != '0);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_addr_d  = cur_addr_q;
    stride_d    = stride_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          remaining_d = cmd_copy_count;
          cur_addr_d  = cmd_addr;
          stride_d    = cmd_stride;
          if (cmd_copy_count != 5'd0) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (handshake) begin
          cur_addr_d  = cur_addr_q + stride_q;
          remaining_d = remaining_q - 5'd1;
          if (remaining_q == 5'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    outstanding_d = outstanding_q + CW'(handshake) - CW'(arrive_ok);
    occupied_d    = occupied_q + CW'(tile_arrive) - CW'(consume_ok);
    err_d         = err_q || (tile_arrive && !arrive_ok) || (tile_consume && !consume_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      cur_addr_q    <= '0;
      stride_q      <= '0;
      outstanding_q <= '0;
      occupied_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      cur_addr_q    <= cur_addr_d;
      stride_q      <= stride_d;
      outstanding_q <= outstanding_d;
      occupied_q    <= occupied_d;
      err_q         <= err_d;
    end
  end

  assign req_addr    = cur_addr_q;
  assign outstanding = outstanding_q;
  assign occupied    = occupied_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_prefetch_credit_controller.sv
// tb/tb_prefetch_credit_controller.sv - directed self-checking bench for prefetch_credit_controller
module tb_prefetch_credit_controller;

  localparam int L3_DEPTH = 16;
  localparam int CW       = $clog2(L3_DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [4:0]    cmd_copy_count;
  logic [17:0]   cmd_addr;
  logic [17:0]   cmd_stride;
  logic          cmd_re;
  logic          req_valid;
  logic [17:0]   req_addr;
  logic          req_ready;
  logic          tile_arrive;
  logic          tile_consume;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] occupied;
  logic          busy;
  logic          err;

  int checks   = 0;
  int failures = 0;

  prefetch_credit_controller #(.L3_DEPTH(L3_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_copy_count (cmd_copy_count),
    .cmd_addr       (cmd_addr),
    .cmd_stride     (cmd_stride),
    .cmd_re         (cmd_re),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .tile_arrive    (tile_arrive),
    .tile_consume   (tile_consume),
    .outstanding    (outstanding),
    .occupied       (occupied),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid      = 1'b0;
    cmd_copy_count = '0;
    cmd_addr       = '0;
    cmd_stride     = '0;
    tile_arrive    = 1'b0;
    tile_consume   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    req_ready = 1'b0;
    reset     = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_cmd_re"}, {31'd0, cmd_re}, 32'd0);
    check({tag, "_req_valid"}, {31'd0, req_valid}, 32'd0);
    check({tag, "_req_addr"}, {14'd0, req_addr}, 32'd0);
    check({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    check({tag, "_occupied"}, 32'(occupied), 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic push_cmd(input logic [4:0] cnt, input logic [17:0] addr, input logic [17:0] stride);
    cmd_valid      = 1'b1;
    cmd_copy_count = cnt;
    cmd_addr       = addr;
    cmd_stride     = stride;
    #1;
    check("pop_cmd_re", {31'd0, cmd_re}, 32'd1);
    cyc();
    idle_inputs();
  endtask

  int          nre;
  int          nhs;
  logic [1:0]  hist;
  logic        hs;
  logic [17:0] addr0;
  logic        stable;

  initial begin
    idle_inputs();
    req_ready = 1'b0;
    reset     = 1'b0;

    // ---------- reset state ----------
    do_reset();
    check_reset_outputs("rst");

    // ---------- basic: three requests on consecutive cycles ----------
    req_ready = 1'b1;
    push_cmd(5'd3, 18'h00100, 18'h00010);
    nre = 0;
    begin
      logic [17:0] exp_addr [3];
      exp_addr[0] = 18'h00100;
      exp_addr[1] = 18'h00110;
      exp_addr[2] = 18'h00120;
      for (int i = 0; i < 3; i++) begin
        #1;
        if (cmd_re) nre++;
        check($sformatf("basic_valid%0d", i), {31'd0, req_valid}, 32'd1);
        check($sformatf("basic_addr%0d", i), {14'd0, req_addr}, {14'd0, exp_addr[i]});
        cyc();
      end
    end
    #1;
    check("basic_cmd_re_once", nre, 0);
    check("basic_outstanding", 32'(outstanding), 32'd3);
    check("basic_busy", {31'd0, busy}, 32'd0);
    check("basic_idle_valid", {31'd0, req_valid}, 32'd0);

    // ---------- credit limit: 20 requested, 16 issued ----------
    do_reset();
    req_ready = 1'b1;
    push_cmd(5'd20, 18'h01000, 18'h00001);
    hist = 2'b00;
    nhs  = 0;
    for (int i = 0; i < 30; i++) begin
      tile_arrive = hist[1];
      #1;
      hs = req_valid && req_ready;
      if (hs) nhs++;
      cyc();
      hist = {hist[0], hs};
    end
    tile_arrive = 1'b0;
    #1;
    check("credit_issued16", nhs, 16);
    check("credit_valid_low", {31'd0, req_valid}, 32'd0);
    check("credit_occupied", 32'(occupied), 32'd16);
    check("credit_outstanding", 32'(outstanding), 32'd0);
    tile_consume = 1'b1;
    #1;
    check("credit_consume_same_cycle", {31'd0, req_valid}, 32'd0);
    cyc();
    tile_consume = 1'b0;
    #1;
    check("credit_released", {31'd0, req_valid}, 32'd1);
    check("credit_released_addr", {14'd0, req_addr}, 32'h01010);
    cyc();
    #1;
    check("credit_one_only", {31'd0, req_valid}, 32'd0);
    check("credit_outstanding_after", 32'(outstanding), 32'd1);

    // ---------- backpressure ----------
    do_reset();
    req_ready = 1'b0;
    push_cmd(5'd2, 18'h00200, 18'h00004);
    stable = 1'b1;
    addr0  = req_addr;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!req_valid || req_addr != addr0 || outstanding != '0) stable = 1'b0;
      cyc();
    end
    check("bp_addr", {14'd0, addr0}, 32'h00200);
    check("bp_stable", {31'd0, stable}, 32'd1);
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    #1;
    check("bp_one_hs", 32'(outstanding), 32'd1);
    check("bp_next_addr", {14'd0, req_addr}, 32'h00204);
    check("bp_still_busy", {31'd0, busy}, 32'd1);

    // ---------- count=0 and address wrap ----------
    do_reset();
    req_ready = 1'b1;
    push_cmd(5'd0, 18'h00300, 18'h00001);
    #1;
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_valid", {31'd0, req_valid}, 32'd0);
    cyc();
    push_cmd(5'd2, 18'h3FFF0, 18'h00020);
    #1;
    check("wrap_addr0", {14'd0, req_addr}, 32'h3FFF0);
    cyc();
    #1;
    check("wrap_addr1", {14'd0, req_addr}, 32'h00010);
    cyc();
    #1;
    check("wrap_outstanding", 32'(outstanding), 32'd2);

    // ---------- simultaneous events and error ----------
    do_reset();
    req_ready = 1'b1;
    push_cmd(5'd3, 18'h00000, 18'h00001);
    cyc();                       // hs only: out=1 occ=0
    tile_arrive = 1'b1;
    cyc();                       // hs + arrive: out=1 occ=1
    tile_consume = 1'b1;
    #1;
    check("sim_valid", {31'd0, req_valid}, 32'd1);
    cyc();                       // hs + arrive + consume: unchanged
    idle_inputs();
    #1;
    check("sim_outstanding", 32'(outstanding), 32'd1);
    check("sim_occupied", 32'(occupied), 32'd1);
    check("sim_no_err", {31'd0, err}, 32'd0);
    tile_arrive = 1'b1;
    cyc();                       // out=0 occ=2
    cyc();                       // underflow: err, out stays 0, occ=3
    tile_arrive = 1'b0;
    #1;
    check("err_set", {31'd0, err}, 32'd1);
    check("err_out_zero", 32'(outstanding), 32'd0);
    check("err_occupied", 32'(occupied), 32'd3);
    for (int i = 0; i < 3; i++) cyc();
    check("err_sticky", {31'd0, err}, 32'd1);

    // ---------- reset mid-command ----------
    do_reset();
    req_ready = 1'b1;
    push_cmd(5'd6, 18'h00400, 18'h00008);
    cyc();
    cyc();                       // two handshakes, remaining=4
    #1;
    check("mid_outstanding", 32'(outstanding), 32'd2);
    req_ready = 1'b0;
    reset     = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset_outputs("mid_rst");
    req_ready = 1'b1;
    push_cmd(5'd1, 18'h00055, 18'h00001);
    #1;
    check("restart_addr", {14'd0, req_addr}, 32'h00055);
    check("restart_valid", {31'd0, req_valid}, 32'd1);
    cyc();
    #1;
    check("restart_outstanding", 32'(outstanding), 32'd1);
    check("restart_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefetch_credit_controller.md
# prefetch_credit_controller

Sequences main-memory read requests from the prefetch command FIFO into the packet sender. Each prefetch command becomes a series of single-tile read requests at strided addresses. A request is issued only when the L3 tile FIFO is guaranteed to have room for the returning tile. The block sits between `packet_send_fifo_mem_read_request` and `PacketSender`'s read-request port, and prevents L3 overflow (`mem_read_completion_fifo_err`).

## Interface
Parameters:
- `L3_DEPTH`, 16: capacity of the L3 tile FIFO, in tiles.
- `CW`, `$clog2(L3_DEPTH+1)`: width of the credit counters.

Ports:
- `clk` in 1: the single system clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: a prefetch command is available; the command fields are valid in the same cycle (first-word fall-through).
- `cmd_copy_count` in 5: number of tiles to fetch.
- `cmd_addr` in 18: main-memory address of the first tile.
- `cmd_stride` in 18: address increment between tiles.
- `cmd_re` out 1: one-cycle pop of the command FIFO.
- `req_valid` out 1: a tile read request is presented.
- `req_addr` out 18: address of the presented request.
- `req_ready` in 1: the sender accepts the request this cycle.
- `tile_arrive` in 1: L3 write strobe; a requested tile has been received.
- `tile_consume` in 1: L3 read strobe; the DMA pipeline has popped a tile.
- `outstanding` out CW: requests accepted but not yet arrived.
- `occupied` out CW: tiles arrived but not yet consumed.
- `busy` out 1: high whenever the block is not in IDLE.
- `err` out 1: sticky protocol error flag.

## Operation
- FSM states are IDLE and ISSUE.
- In IDLE with `cmd_valid`:
  - Assert `cmd_re` for that cycle.
  - Latch `remaining` = `cmd_copy_count`, `cur_addr` = `cmd_addr`, `stride` = `cmd_stride`.
  - Go to ISSUE if `cmd_copy_count` != 0. Otherwise stay in IDLE; the command is discarded with no request.
- In ISSUE, credit is available when `outstanding + occupied < L3_DEPTH`. The sum is computed at CW+1 bits.
- `req_valid` is asserted whenever the FSM is in ISSUE and credit is available.
- Once `req_valid` is asserted, it holds with `req_addr` stable until `req_ready`. Credit can only decrease through issuance, so the hold never violates the credit rule.
- On the handshake (`req_valid & req_ready`):
  - `cur_addr` <= `cur_addr + stride` mod 2^18 (wrap-around permitted).
  - `remaining` decrements.
  - `outstanding` increments.
  - If `remaining` was 1, return to IDLE.
- Counter updates; all increments and decrements in the same cycle net out:
  - `outstanding` += handshake, -= `tile_arrive`.
  - `occupied` += `tile_arrive`, -= `tile_consume`.
- Error conditions:
  - `tile_arrive` with `outstanding`==0 sets `err` and leaves `outstanding` at 0. `occupied` still increments.
  - `tile_consume` with `occupied`==0 sets `err` and leaves `occupied` at 0.
- `err` clears only on `reset`.
- `req_addr` = `cur_addr`. It is don't-care while `req_valid`=0, but is driven with the registered value.

## Timing
- Reset values: `cmd_re`=0, `req_valid`=0, `req_addr`=0, `outstanding`=0, `occupied`=0, `busy`=0, `err`=0, state IDLE.
- Reset mid-command drops the rest of that command and clears both counters.
- `cmd_re` is combinational from state and `cmd_valid`. It is high only in IDLE.
- First request: `req_valid` rises the cycle after the command is popped, provided credit is available.
- Throughput is one request per cycle while `req_ready` and credit hold.
- Between consecutive commands there is one IDLE cycle; IDLE never asserts `req_valid`.
- `req_valid` is registered-state based. It depends combinationally only on the state and counter registers, never on `req_ready`.
- Credit freed by `tile_consume` in cycle t is usable for `req_valid` in cycle t+1.
- A handshake and a `tile_arrive` in the same cycle leave `outstanding` unchanged.

## Test plan
- Reset, then command {count=3, addr=0x00100, stride=0x00010} with `req_ready`=1 and no tiles returning:
  - `cmd_re` pulses once.
  - Requests 0x00100, 0x00110, 0x00120 appear on consecutive cycles.
  - `outstanding`=3, `busy` falls.
- Credit limit with `L3_DEPTH`=16, command count=20, no consume, tiles arriving 2 cycles after each request:
  - Exactly 16 requests are issued, then `req_valid` stays low.
  - One `tile_consume` releases exactly one further request on the following cycle.
- Backpressure: hold `req_ready`=0 for 5 cycles with `req_valid` high:
  - `req_addr` is constant and `outstanding` is unchanged.
  - Release `req_ready`: a single handshake occurs.
- Edge cases:
  - count=0 pops the command in one cycle with no request and `busy` stays 0.
  - addr=0x3FFF0, stride=0x00020 wraps the second request to 0x00010.
- Simultaneous events:
  - Handshake plus `tile_arrive` plus `tile_consume` in one cycle leaves both counters unchanged.
  - `tile_arrive` with `outstanding`=0 sets `err`=1, which persists until `reset`.
- Reset during ISSUE with remaining=4:
  - All outputs return to their reset values next cycle.
  - The next command starts cleanly.
